// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares the single memory/MIO port between the CPU
// controller and a secondary bus master (DMA). CPU has priority; a
// consecutive-CPU-grant streak counter forces a DMA grant so the DMA
// master cannot starve. One access = 1 IDLE + MEM_LAT ACC + 1 DONE cycle.
module mio_bus_arbiter #(
    parameter int MEM_LAT       = 2,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ready,
    output logic [31:0] dma_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  grant_out,
    output logic [1:0]  state_out
);

    localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STREAK_W = $clog2(MAX_CPU_BURST + 1);

    localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(MEM_LAT - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_BURST);

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_DMA  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     wait_cnt;
    logic [STREAK_W-1:0]  streak;
    logic [1:0]           grant_q;
    logic                 lat_we;
    logic [31:0]          lat_addr;
    logic [31:0]          lat_wdata;
    logic [31:0]          rdata_q;

    logic any_req;
    logic dma_wins;

    // Arbitration decision; only acted on while IDLE.
    assign any_req  = cpu_req | dma_req;
    assign dma_wins = dma_req & (~cpu_req | (streak >= STREAK_MAX));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and port-control decode.
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_ready = 1'b0;
        dma_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                mem_en = 1'b1;
                mem_we = lat_we;
                if (wait_cnt == LAST_CNT) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                cpu_ready = (grant_q == GNT_CPU);
                dma_ready = (grant_q == GNT_DMA);
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, wait counter, streak counter, grant and read capture.
    // The read register is reset too, so both rdata ports read 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            streak    <= '0;
            grant_q   <= GNT_NONE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        wait_cnt <= '0;
                        if (dma_wins) begin
                            grant_q   <= GNT_DMA;
                            lat_we    <= dma_we;
                            lat_addr  <= dma_addr;
                            lat_wdata <= dma_wdata;
                            streak    <= '0;
                        end else begin
                            grant_q   <= GNT_CPU;
                            lat_we    <= cpu_we;
                            lat_addr  <= cpu_addr;
                            lat_wdata <= cpu_wdata;
                            // Count only CPU grants that made DMA wait.
                            if (!dma_req) begin
                                streak <= '0;
                            end else if (streak != STREAK_MAX) begin
                                streak <= streak + 1'b1;
                            end
                        end
                    end
                end
                ST_ACC: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == LAST_CNT && !lat_we) begin
                        rdata_q <= mem_rdata;
                    end
                end
                ST_DONE: begin
                    grant_q <= GNT_NONE;
                end
                default: begin
                    grant_q <= GNT_NONE;
                end
            endcase
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign cpu_rdata = rdata_q;
    assign dma_rdata = rdata_q;
    assign grant_out = grant_q;
    assign state_out = state;

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Shares the single memory/MIO port between the multicycle CPU controller and a secondary bus master (DMA/peripheral engine).
- Each master issues a level request and holds it until it sees a one-cycle ready pulse.
- The arbiter latches the winning request, drives the memory port for a fixed number of wait cycles, then returns read data and ready.
- Arbitration is CPU-priority, with a starvation guard that forces a DMA grant after a run of consecutive CPU grants.

Parameters:
MEM_LAT, 2, number of cycles the memory port is held active per access (>=1)
MAX_CPU_BURST, 4, consecutive CPU grants allowed while dma_req is pending before DMA is forced (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request, level, held until cpu_ready
cpu_we  input  1  CPU write enable (1=write, 0=read)
cpu_addr  input  32  CPU byte address
cpu_wdata  input  32  CPU write data
cpu_ready  output  1  one-cycle pulse: CPU access complete (maps to controller MIO_ready)
cpu_rdata  output  32  read data for CPU, valid while cpu_ready=1
dma_req  input  1  DMA access request, level, held until dma_ready
dma_we  input  1  DMA write enable
dma_addr  input  32  DMA byte address
dma_wdata  input  32  DMA write data
dma_ready  output  1  one-cycle pulse: DMA access complete
dma_rdata  output  32  read data for DMA, valid while dma_ready=1
mem_en  output  1  memory port active
mem_we  output  1  memory write strobe
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid on the last active cycle
grant_out  output  2  01=CPU owns port, 10=DMA owns port, 00=none
state_out  output  2  FSM state: 0=IDLE, 1=ACC, 2=DONE

Behaviour:
- Reset (asynchronous, mid-access included): state IDLE; all outputs 0 (mem_en, mem_we, mem_addr, mem_wdata, cpu_ready, dma_ready, both rdata, grant_out); wait counter 0; streak 0. An in-flight access is abandoned and no ready pulse is issued.
- IDLE:
  - No request: stay in IDLE; grant_out=00.
  - Request present: pick the winner per the arbitration rules. Latch its we/addr/wdata into internal registers, set grant_out, load wait counter with 0, go to ACC.
- ACC:
  - mem_en=1; mem_we=latched we; mem_addr and mem_wdata driven from the latched registers.
  - Master inputs are ignored in this state.
  - Counter increments each cycle. When it reaches MEM_LAT-1, capture mem_rdata into the read register (reads only; writes leave it unchanged) and go to DONE.
  - The state therefore lasts exactly MEM_LAT cycles.
- DONE:
  - mem_en=0, mem_we=0.
  - Exactly one cycle; the owner's ready=1. The other ready stays 0.
  - Go to IDLE; grant_out clears to 00 on the transition.
  - No request sampling in DONE, so a master that still shows req during its ready cycle does not trigger a duplicate access.
- Latency: req sampled at IDLE edge t → ACC for cycles t+1..t+MEM_LAT → ready high in cycle t+MEM_LAT+1 → IDLE again at t+MEM_LAT+2. Minimum gap between grants is 1 IDLE cycle.
- cpu_rdata and dma_rdata are both driven by the shared read register; each is only meaningful while its own ready is 1.
- Arbitration (evaluated in IDLE only):
  - Only one master requesting: that master wins.
  - Both requesting: CPU wins unless streak >= MAX_CPU_BURST, in which case DMA wins.
  - CPU granted while dma_req=1: streak increments, saturating at MAX_CPU_BURST.
  - CPU granted while dma_req=0, or any DMA grant: streak resets to 0.
  - Streak width is clog2(MAX_CPU_BURST+1).
- Requests arriving during ACC or DONE wait until the next IDLE cycle. There is no preemption.
- Latched address and wdata hold their last values after an access; mem_addr and mem_wdata may show stale values while mem_en=0.

Test Plan:
- Reset, then single CPU read: cpu_addr=0x00000010, mem_rdata=0xDEADBEEF during ACC → mem_en high 2 cycles with mem_addr=0x10, mem_we=0; cpu_ready pulses exactly 1 cycle with cpu_rdata=0xDEADBEEF; dma_ready stays 0.
- DMA write alone: dma_we=1, addr=0x200, wdata=0x12345678 → mem_we=1 for 2 cycles with those values; dma_ready pulses once; grant_out=10 during ACC.
- Both held continuously with CPU re-requesting immediately after each ready → grant order CPU,CPU,CPU,CPU,DMA,CPU…; the streak then restarts at 0 after the DMA grant.
- CPU keeps req high through its ready cycle and then drops it → exactly one access and one cpu_ready; no second mem_en burst.
- Assert reset during the second ACC cycle of a CPU read → all outputs 0 immediately; no cpu_ready; state_out=0; the next request is served normally.
- Simultaneous requests from reset with dma_req held → CPU wins the first grant; DMA is served within 4 CPU grants.
